// File: rtl/sid_audio_decimator_if.sv
// Sample/frame bus between the SID audio source, the decimator and the I2S output stage.
// The master drives samples and the word clock; the slave publishes one filtered sample per frame.
interface sid_audio_decimator_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        lck;
    logic [15:0] smp;
    logic        smp_upd;
    logic        stale;

    modport master (
        output in_valid,
        output in_data,
        output lck,
        input  smp,
        input  smp_upd,
        input  stale
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  lck,
        output smp,
        output smp_upd,
        output stale
    );
endinterface

// File: rtl/sid_audio_decimator.sv
// Boxcar low-pass plus saturating gain for SID audio samples; publishes one sample per I2S
// frame, re-latched on every falling edge of the word clock.
module sid_audio_decimator #(
    parameter int unsigned LOG2_WIN    = 4,
    parameter bit          IN_UNSIGNED = 1'b1,
    parameter int unsigned GAIN_SHIFT  = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    sid_audio_decimator_if.slave  bus
);

    localparam int unsigned WIN  = 1 << LOG2_WIN;
    localparam int unsigned AccW = 16 + LOG2_WIN;

    logic signed [15:0]     line_q [WIN];
    logic [LOG2_WIN-1:0]    wr_ptr_q;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] x_ext, old_ext;
    logic signed [15:0]     x, old;
    logic signed [15:0]     avg;
    logic signed [20:0]     gained;
    logic [15:0]            sat;

    logic        lck_q, fall;
    logic        seen_q, seen_d;
    logic [15:0] smp_q, smp_d;
    logic        smp_upd_q;
    logic        stale_q, stale_d;

    always_comb begin
        x       = IN_UNSIGNED ? {~bus.in_data[15], bus.in_data[14:0]} : bus.in_data;
        old     = line_q[wr_ptr_q];
        x_ext   = {{LOG2_WIN{x[15]}}, x};
        old_ext = {{LOG2_WIN{old[15]}}, old};
        // Running sum: the oldest entry leaves as the new one enters.
        acc_d   = acc_q + x_ext - old_ext;
    end

    always_comb begin
        // Dropping the low bits of a signed sum is a floor divide by the window length.
        avg    = acc_q[AccW-1:LOG2_WIN];
        gained = {{5{avg[15]}}, avg} <<< GAIN_SHIFT;
        if (gained > 21'sd32767) begin
            sat = 16'h7FFF;
        end else if (gained < -21'sd32768) begin
            sat = 16'h8000;
        end else begin
            sat = gained[15:0];
        end
    end

    always_comb begin
        fall    = lck_q & ~bus.lck;
        smp_d   = smp_q;
        stale_d = stale_q;
        seen_d  = seen_q;
        if (fall) begin
            smp_d   = sat;
            stale_d = ~seen_q;
            seen_d  = 1'b0;
        end
        // A sample arriving on the fall cycle counts toward the next frame.
        if (bus.in_valid) begin
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                line_q[i] <= '0;
            end
            acc_q    <= '0;
            wr_ptr_q <= '0;
        end else if (bus.in_valid) begin
            line_q[wr_ptr_q] <= x;
            acc_q            <= acc_d;
            wr_ptr_q         <= wr_ptr_q + LOG2_WIN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lck_q     <= 1'b0;
            smp_q     <= '0;
            smp_upd_q <= 1'b0;
            stale_q   <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            lck_q     <= bus.lck;
            smp_q     <= smp_d;
            smp_upd_q <= fall;
            stale_q   <= stale_d;
            seen_q    <= seen_d;
        end
    end

    assign bus.smp     = smp_q;
    assign bus.smp_upd = smp_upd_q;
    assign bus.stale   = stale_q;

endmodule

// File: tb/tb_sid_audio_decimator.sv
// Randomized bench: four decimator configurations share one stimulus stream and are compared
// every cycle against a window-sum reference model built from the raw sample history.
module tb_sid_audio_decimator;

    localparam int NDut = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        lck = 1'b0;

    always #5 clk = ~clk;

    sid_audio_decimator_if if0 ();
    sid_audio_decimator_if if1 ();
    sid_audio_decimator_if if2 ();
    sid_audio_decimator_if if3 ();

    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if0.lck      = lck;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    assign if1.lck      = lck;
    assign if2.in_valid = in_valid;
    assign if2.in_data  = in_data;
    assign if2.lck      = lck;
    assign if3.in_valid = in_valid;
    assign if3.in_data  = in_data;
    assign if3.lck      = lck;

    sid_audio_decimator #(.LOG2_WIN(4), .IN_UNSIGNED(1'b1), .GAIN_SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    sid_audio_decimator #(.LOG2_WIN(4), .IN_UNSIGNED(1'b0), .GAIN_SHIFT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    sid_audio_decimator #(.LOG2_WIN(4), .IN_UNSIGNED(1'b0), .GAIN_SHIFT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));
    sid_audio_decimator #(.LOG2_WIN(2), .IN_UNSIGNED(1'b1), .GAIN_SHIFT(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    logic [15:0] smp_w   [NDut];
    logic        upd_w   [NDut];
    logic        stale_w [NDut];

    assign smp_w[0] = if0.smp;  assign upd_w[0] = if0.smp_upd;  assign stale_w[0] = if0.stale;
    assign smp_w[1] = if1.smp;  assign upd_w[1] = if1.smp_upd;  assign stale_w[1] = if1.stale;
    assign smp_w[2] = if2.smp;  assign upd_w[2] = if2.smp_upd;  assign stale_w[2] = if2.stale;
    assign smp_w[3] = if3.smp;  assign upd_w[3] = if3.smp_upd;  assign stale_w[3] = if3.stale;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] hist [$];
    logic [15:0] stim [$];
    logic [15:0] exp_smp [NDut];
    logic        exp_upd;
    logic        exp_stale;
    logic        seen;
    logic        prev_lck;
    int          phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cfg_lg(input int k);
        return (k == 3) ? 2 : 4;
    endfunction

    function automatic bit cfg_uns(input int k);
        return (k == 0 || k == 3);
    endfunction

    function automatic int cfg_gain(input int k);
        case (k)
            2:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    // Mean of the last 2**lg samples (missing ones count as zero), scaled and clamped.
    function automatic logic [15:0] model_smp(input int k);
        int          sum;
        int          n;
        int          idx;
        int          v;
        logic [15:0] raw;
        sum = 0;
        n   = 1 << cfg_lg(k);
        for (int i = 0; i < n; i++) begin
            idx = hist.size() - 1 - i;
            if (idx >= 0) begin
                raw = hist[idx];
                if (cfg_uns(k)) sum += int'(raw) - 32768;
                else            sum += int'(signed'(raw));
            end
        end
        v = (sum >>> cfg_lg(k)) * (1 << cfg_gain(k));
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic compare_all();
        for (int k = 0; k < NDut; k++) begin
            check_eq($sformatf("smp%0d", k), {16'h0, smp_w[k]}, {16'h0, exp_smp[k]});
            check_eq($sformatf("upd%0d", k), {31'h0, upd_w[k]}, {31'h0, exp_upd});
            check_eq($sformatf("stale%0d", k), {31'h0, stale_w[k]}, {31'h0, exp_stale});
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        lck      = 1'b0;
        hist.delete();
        stim.delete();
        for (int k = 0; k < NDut; k++) exp_smp[k] = '0;
        exp_upd   = 1'b0;
        exp_stale = 1'b0;
        seen      = 1'b0;
        prev_lck  = 1'b0;
        phase     = 0;
        #1;
        compare_all();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic l);
        logic fall;
        in_valid = v;
        in_data  = d;
        lck      = l;
        @(posedge clk);
        fall     = prev_lck & ~l;
        prev_lck = l;
        exp_upd  = fall;
        if (fall) begin
            for (int k = 0; k < NDut; k++) exp_smp[k] = model_smp(k);
            exp_stale = ~seen;
            seen      = 1'b0;
        end
        if (v) begin
            hist.push_back(d);
            if (hist.size() > 128) void'(hist.pop_front());
            seen = 1'b1;
        end
        #1;
        compare_all();
    endtask

    // Word clock: 256 cycles high then 256 low; stored samples are strobed in at random.
    task automatic run(input int ncyc, input int prob, input bit on_fall);
        logic        v;
        logic [15:0] d;
        for (int c = 0; c < ncyc; c++) begin
            v = 1'b0;
            d = '0;
            if (stim.size() > 0 &&
                (($urandom % prob) == 0 || (on_fall && phase == 256))) begin
                v = 1'b1;
                d = stim.pop_front();
            end
            cycle(v, d, (phase < 256));
            phase = (phase + 1) % 512;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        // Idle frames: zero output, update pulse each frame, stale from first update
        do_reset();
        run(1024, 8, 1'b0);
        check_eq("t1_stale", {31'h0, stale_w[0]}, 32'h1);
        check_eq("t1_smp", {16'h0, smp_w[0]}, 32'h0);

        // Full window of offset-binary 0xC000
        do_reset();
        repeat (16) stim.push_back(16'hC000);
        run(1024, 8, 1'b0);
        check_eq("t2_smp", {16'h0, smp_w[0]}, 32'h4000);

        // Half window of 0xFFFF
        do_reset();
        repeat (8) stim.push_back(16'hFFFF);
        run(1024, 8, 1'b0);
        check_eq("t3_smp", {16'h0, smp_w[0]}, 32'h3FFF);

        // Signed 1..20, exercises pointer wrap
        do_reset();
        for (int i = 1; i <= 20; i++) stim.push_back(16'(i));
        run(1024, 8, 1'b0);
        check_eq("t4_smp", {16'h0, smp_w[1]}, 32'd12);

        // Gain saturation both ways
        do_reset();
        repeat (16) stim.push_back(16'h6000);
        run(1024, 8, 1'b0);
        check_eq("t5_pos", {16'h0, smp_w[2]}, 32'h7FFF);
        repeat (16) stim.push_back(16'hA000);
        run(1024, 8, 1'b0);
        check_eq("t5_neg", {16'h0, smp_w[2]}, 32'h8000);

        // Samples forced onto the fall cycle
        do_reset();
        repeat (40) stim.push_back(16'($urandom));
        run(2048, 200, 1'b1);

        // Random traffic, then a reset mid-frame and more traffic
        for (int r = 0; r < 6; r++) begin
            repeat (30) stim.push_back(16'($urandom));
            run(512, 12, 1'b0);
        end
        run(300, 12, 1'b0);
        do_reset();
        for (int r = 0; r < 4; r++) begin
            repeat (40) stim.push_back(16'($urandom));
            run(512, 6, (r % 2) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
